// File: rtl/rat_pkg.sv
// Shared types and constants for the RAT MCU instruction-fetch stage.
package rat_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_INTR   = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_FROM_IMMED = 2'd0,
        PC_FROM_STACK = 2'd1,
        PC_FROM_VEC   = 2'd2,
        PC_FROM_ZERO  = 2'd3
    } pc_sel_t;

    localparam logic [9:0] INTR_VEC_ADDR = 10'h3FF;

endpackage

// File: rtl/prog_counter.sv
// Program counter register with 4:1 load-source mux and wrapping increment.
module prog_counter
    import rat_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] INTR_VEC = INTR_VEC_ADDR
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD,
    input  logic              INC,
    input  logic [1:0]        SEL,
    input  logic [ADDR_W-1:0] FROM_IMMED,
    input  logic [ADDR_W-1:0] FROM_STACK,
    output logic [ADDR_W-1:0] COUNT
);

    logic [ADDR_W-1:0] pc_p0;
    logic [ADDR_W-1:0] mux_out;

    always_comb begin
        mux_out = '0;
        case (pc_sel_t'(SEL))
            PC_FROM_IMMED: mux_out = FROM_IMMED;
            PC_FROM_STACK: mux_out = FROM_STACK;
            PC_FROM_VEC:   mux_out = INTR_VEC;
            PC_FROM_ZERO:  mux_out = '0;
            default:       mux_out = '0;
        endcase
    end

    // Load wins over increment; increment wraps naturally at the top of the ROM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_p0 <= '0;
        end else if (LD) begin
            pc_p0 <= mux_out;
        end else if (INC) begin
            pc_p0 <= pc_p0 + ADDR_W'(1);
        end
    end

    assign COUNT = pc_p0;

endmodule

// File: rtl/prog_fetch.sv
// RAT MCU fetch stage: PC ownership, ROM latency absorption, IR register and
// interrupt vector sequencing.
module prog_fetch
    import rat_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                INSTR_W  = 18,
    parameter logic [ADDR_W-1:0] INTR_VEC = INTR_VEC_ADDR
) (
    input  logic               CLK,
    input  logic               RST,
    output logic [ADDR_W-1:0]  PROG_ADDR,
    input  logic [INSTR_W-1:0] PROG_IR,
    output logic [INSTR_W-1:0] IR,
    output logic               IR_VALID,
    input  logic               EXEC_DONE,
    input  logic               PC_LD,
    input  logic [1:0]         PC_MUX_SEL,
    input  logic [ADDR_W-1:0]  FROM_IMMED,
    input  logic [ADDR_W-1:0]  FROM_STACK,
    input  logic               INTR,
    input  logic               INT_EN,
    output logic               INT_ACK,
    output logic [ADDR_W-1:0]  PC_COUNT
);

    fetch_state_t       state_p0;
    fetch_state_t       state_nx;
    logic [INSTR_W-1:0] ir_p1;
    logic               ir_valid_p1;
    logic               int_ack_p1;
    logic               pending_p0;
    logic               pc_ld;
    logic               pc_inc;
    logic [1:0]         pc_sel;
    logic [ADDR_W-1:0]  pc;

    prog_counter #(
        .ADDR_W   (ADDR_W),
        .INTR_VEC (INTR_VEC)
    ) u_pc (
        .CLK        (CLK),
        .RST        (RST),
        .LD         (pc_ld),
        .INC        (pc_inc),
        .SEL        (pc_sel),
        .FROM_IMMED (FROM_IMMED),
        .FROM_STACK (FROM_STACK),
        .COUNT      (pc)
    );

    always_comb begin
        state_nx = state_p0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_sel   = PC_MUX_SEL;
        case (state_p0)
            ST_FETCH:  state_nx = ST_DECODE;
            ST_DECODE: state_nx = ST_EXEC;
            ST_EXEC: begin
                if (EXEC_DONE) begin
                    pc_ld    = PC_LD;
                    pc_inc   = !PC_LD;
                    state_nx = (pending_p0 && INT_EN) ? ST_INTR : ST_FETCH;
                end
            end
            ST_INTR: begin
                pc_ld    = 1'b1;
                pc_sel   = PC_FROM_VEC;
                state_nx = ST_FETCH;
            end
            default:   state_nx = ST_FETCH;
        endcase
    end

    // ROM data is valid in DECODE; IR_VALID/INT_ACK are registered copies of the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_p0    <= ST_FETCH;
            ir_p1       <= '0;
            ir_valid_p1 <= 1'b0;
            int_ack_p1  <= 1'b0;
            pending_p0  <= 1'b0;
        end else begin
            state_p0    <= state_nx;
            ir_valid_p1 <= (state_nx == ST_EXEC);
            int_ack_p1  <= (state_nx == ST_INTR);
            if (state_p0 == ST_DECODE) begin
                ir_p1 <= PROG_IR;
            end
            // Taking the interrupt clears pending and drops any INTR arriving that same cycle.
            if (state_p0 == ST_INTR) begin
                pending_p0 <= 1'b0;
            end else if (INTR) begin
                pending_p0 <= 1'b1;
            end
        end
    end

    assign PROG_ADDR = pc;
    assign PC_COUNT  = pc;
    assign IR        = ir_p1;
    assign IR_VALID  = ir_valid_p1;
    assign INT_ACK   = int_ack_p1;

endmodule

// File: doc/prog_fetch.md
# prog_fetch

Instruction-fetch stage of the RAT MCU, directly upstream of the 1024×18 program ROM. It owns the 10-bit program counter and drives the ROM address. It absorbs the ROM's one-cycle synchronous read latency and holds the fetched instruction in an IR register for the control unit. It also sequences the interrupt vector jump.

## Interface
Parameters:
- ADDR_W, 10, program counter / ROM address width
- INSTR_W, 18, instruction width
- INTR_VEC, 10'h3FF, interrupt vector address

Ports:
- CLK  in  1  system clock; also clocks the ROM
- RST  in  1  synchronous, active-high reset
- PROG_ADDR  out  ADDR_W  ROM address; always equals PC
- PROG_IR  in  INSTR_W  ROM data; valid one cycle after PROG_ADDR is presented
- IR  out  INSTR_W  registered instruction for the control unit
- IR_VALID  out  1  IR holds the instruction at PC_COUNT
- EXEC_DONE  in  1  control unit has finished executing IR; ignored unless IR_VALID
- PC_LD  in  1  on EXEC_DONE, load PC from the mux instead of incrementing
- PC_MUX_SEL  in  2  0 = FROM_IMMED, 1 = FROM_STACK, 2 = INTR_VEC, 3 = 10'h000
- FROM_IMMED  in  ADDR_W  branch/call target from IR
- FROM_STACK  in  ADDR_W  return address from scratch RAM
- INTR  in  1  one-cycle interrupt request pulse
- INT_EN  in  1  interrupt enable (I flag)
- INT_ACK  out  1  one-cycle pulse: interrupt taken; control unit pushes PC_COUNT and clears I
- PC_COUNT  out  ADDR_W  current PC

## Operation
- FSM states are ST_FETCH, ST_DECODE, ST_EXEC and ST_INTR.
- **Reset:**
  - PC = 0, state = ST_FETCH, IR = 0.
  - IR_VALID = 0, INT_ACK = 0, pending = 0.
- **ST_FETCH:** PROG_ADDR = PC. The ROM latches rom[PC] at the edge. Next state is ST_DECODE.
- **ST_DECODE:** PROG_IR is valid. IR <= PROG_IR at the edge. Next state is ST_EXEC.
- **ST_EXEC:**
  - IR_VALID = 1. IR and PC are held until EXEC_DONE.
  - On EXEC_DONE:
    - PC <= PC_LD ? mux(PC_MUX_SEL) : PC + 1. Increment wraps 10'h3FF to 10'h000.
    - Next state is ST_INTR if (pending & INT_EN), else ST_FETCH.
- **ST_INTR:**
  - INT_ACK = 1. PC_COUNT shows the already-updated return address.
  - PC <= INTR_VEC, pending <= 0. Next state is ST_FETCH.
- **Pending flag:**
  - Set by INTR in any state.
  - In ST_INTR the clear has priority over a simultaneous INTR; that pulse is lost.
  - If INT_EN = 0, pending persists until INT_EN rises and an EXEC_DONE occurs.
- **Ignored inputs:**
  - PC_LD and PC_MUX_SEL are ignored without EXEC_DONE.
  - EXEC_DONE is ignored outside ST_EXEC.
- **RST mid-operation:** returns everything to reset values at the next edge. An in-flight instruction and any pending interrupt are discarded.

## Timing
- Fetch latency: 2 cycles from entering ST_FETCH to IR_VALID = 1.
- Minimum instruction period is 3 cycles: FETCH, DECODE, and EXEC with EXEC_DONE asserted in its first cycle.
- IR_VALID is registered and falls in the cycle after EXEC_DONE.
- Interrupt path adds 1 cycle (ST_INTR) before the fetch at INTR_VEC.
- PROG_ADDR and PC_COUNT are combinational copies of the PC register. They change only on the EXEC_DONE edge, the ST_INTR edge, or reset.

## Structure
- Package rat_pkg holds:
  - the fetch_state_t enum (ST_FETCH, ST_DECODE, ST_EXEC, ST_INTR);
  - the pc_sel_t enum (PC_FROM_IMMED, PC_FROM_STACK, PC_FROM_VEC, PC_FROM_ZERO);
  - INTR_VEC_ADDR = 10'h3FF.
- One sub-module, prog_counter, contains the PC register, the 4:1 source mux, and the increment. Its controls are LD, INC and RST, and the FSM drives them.
- The FSM, IR register and pending flag live in prog_fetch.

## Test plan
- **Reset then run:** ROM holds 0x00001 at address 0 and 0x00002 at address 1; EXEC_DONE is pulsed each time IR_VALID rises.
  - Required: IR = 0x00001 on the first IR_VALID with PC_COUNT = 0, then 0x00002 with PC_COUNT = 1, at a 3-cycle period.
- **Branch:** at PC = 5, EXEC_DONE with PC_LD = 1, PC_MUX_SEL = 0, FROM_IMMED = 0x123.
  - Required: PROG_ADDR = 0x123 next cycle; the next IR = rom[0x123].
- **Return and wrap:**
  - PC_MUX_SEL = 1 with FROM_STACK = 0x3FF loads 0x3FF.
  - The next plain EXEC_DONE gives PC = 0x000.
- **Interrupt:** INTR pulses during ST_DECODE at PC = 7 with INT_EN = 1.
  - Required: after EXEC_DONE, a 1-cycle INT_ACK with PC_COUNT = 8, then PROG_ADDR = 0x3FF.
  - With INT_EN = 0, INT_ACK stays low until INT_EN rises and the next EXEC_DONE occurs.
- **Reset mid-exec:** RST is asserted in ST_EXEC at PC = 0x040 with pending = 1.
  - Required next cycle: PC = 0, IR_VALID = 0, INT_ACK = 0; no interrupt is taken afterwards.
